// File: rtl/pattern_scheduler.sv
// Frame-synchronous pattern scheduler: selects the active pattern generator, inserts
// whole blank frames between patterns and broadcasts the animation step size.
module pattern_scheduler #(
  parameter int NUM_PATTERNS = 4,
  parameter int DWELL_FRAMES = 600,
  parameter int BLANK_FRAMES = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            next_frame,
  input  logic                            btn_next,
  input  logic                            auto_en,
  input  logic                            speed_up,
  input  logic                            speed_down,
  output logic [NUM_PATTERNS-1:0]         pattern_enable,
  output logic [$clog2(NUM_PATTERNS)-1:0] pattern_sel,
  output logic [2:0]                      step_size,
  output logic                            blank
);

  localparam int SW = $clog2(NUM_PATTERNS);
  localparam int DW = $clog2(DWELL_FRAMES + 1);
  localparam int BW = $clog2(BLANK_FRAMES + 1);

  localparam logic [SW-1:0] SEL_LAST   = SW'(NUM_PATTERNS - 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_FRAMES - 1);
  localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_FRAMES - 1);

  typedef enum logic {
    ST_RUN,
    ST_BLANK
  } state_t;

  state_t                  state, state_nxt;
  logic                    btn_s1, btn_s2, btn_d;
  logic                    btn_rise;
  logic                    pending, pending_nxt;
  logic [DW-1:0]           dwell_cnt, dwell_nxt;
  logic [BW-1:0]           blank_cnt, blank_cnt_nxt;
  logic [SW-1:0]           sel_nxt;
  logic [NUM_PATTERNS-1:0] enable_nxt;
  logic                    blank_out_nxt;
  logic [2:0]              step_nxt;

  assign btn_rise = btn_s2 & ~btn_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ST_RUN;
      btn_s1         <= 1'b0;
      btn_s2         <= 1'b0;
      btn_d          <= 1'b0;
      pending        <= 1'b0;
      dwell_cnt      <= '0;
      blank_cnt      <= '0;
      pattern_sel    <= '0;
      pattern_enable <= NUM_PATTERNS'(1);
      blank          <= 1'b0;
      step_size      <= 3'd2;
    end else begin
      state          <= state_nxt;
      btn_s1         <= btn_next;
      btn_s2         <= btn_s1;
      btn_d          <= btn_s2;
      pending        <= pending_nxt;
      dwell_cnt      <= dwell_nxt;
      blank_cnt      <= blank_cnt_nxt;
      pattern_sel    <= sel_nxt;
      pattern_enable <= enable_nxt;
      blank          <= blank_out_nxt;
      step_size      <= step_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    pending_nxt   = pending | btn_rise;
    dwell_nxt     = dwell_cnt;
    blank_cnt_nxt = blank_cnt;
    sel_nxt       = pattern_sel;

    case (state)
      ST_RUN: begin
        if (next_frame) begin
          // A switch taken this cycle also swallows an edge detected this cycle.
          if (pending || (auto_en && dwell_cnt == DWELL_LAST)) begin
            state_nxt     = ST_BLANK;
            dwell_nxt     = '0;
            pending_nxt   = 1'b0;
            blank_cnt_nxt = '0;
          end else begin
            dwell_nxt = dwell_cnt + DW'(1);
          end
        end
      end
      ST_BLANK: begin
        dwell_nxt = '0;
        if (next_frame) begin
          if (blank_cnt == BLANK_LAST) begin
            state_nxt = ST_RUN;
            sel_nxt   = (pattern_sel == SEL_LAST) ? '0 : pattern_sel + SW'(1);
          end else begin
            blank_cnt_nxt = blank_cnt + BW'(1);
          end
        end
      end
      default: state_nxt = ST_RUN;
    endcase

    if (!auto_en) dwell_nxt = '0;
  end

  // Registered outputs are derived from next-state so they change on pixel 0.
  always_comb begin
    blank_out_nxt = (state_nxt == ST_BLANK);
    enable_nxt    = '0;
    for (int unsigned i = 0; i < NUM_PATTERNS; i++) begin
      enable_nxt[i] = (state_nxt == ST_RUN) && (sel_nxt == SW'(i));
    end
  end

  always_comb begin
    step_nxt = step_size;
    if (speed_up && !speed_down && step_size != 3'd7) step_nxt = step_size + 3'd1;
    else if (speed_down && !speed_up && step_size != 3'd0) step_nxt = step_size - 3'd1;
  end

endmodule

// File: tb/tb_pattern_scheduler.sv
// Scoreboard bench for pattern_scheduler: expected per-frame outputs are queued by the
// stimulus and checked by a monitor on pixel 0 of every frame.
`timescale 1ns/1ps
module tb_pattern_scheduler;

  localparam int NP    = 3;
  localparam int DF    = 5;
  localparam int BF    = 2;
  localparam int FRAME = 20;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          next_frame = 1'b0;
  logic          btn_next = 1'b0;
  logic          auto_en = 1'b0;
  logic          speed_up = 1'b0;
  logic          speed_down = 1'b0;
  logic [NP-1:0] pattern_enable;
  logic [1:0]    pattern_sel;
  logic [2:0]    step_size;
  logic          blank;

  int checks = 0;
  int passes = 0;
  int fcyc   = 0;

  typedef struct packed {
    logic       b;
    logic [1:0] sel;
    logic [2:0] en;
  } frame_t;

  frame_t sb[$];

  pattern_scheduler #(
    .NUM_PATTERNS(NP),
    .DWELL_FRAMES(DF),
    .BLANK_FRAMES(BF)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .next_frame    (next_frame),
    .btn_next      (btn_next),
    .auto_en       (auto_en),
    .speed_up      (speed_up),
    .speed_down    (speed_down),
    .pattern_enable(pattern_enable),
    .pattern_sel   (pattern_sel),
    .step_size     (step_size),
    .blank         (blank)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(negedge clk);
      fcyc++;
      next_frame = (fcyc % FRAME == 0);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic push_frame(input bit b, input int s, input int n);
    frame_t e;
    e.b   = b;
    e.sel = 2'(s);
    e.en  = b ? 3'b000 : (3'b001 << s);
    repeat (n) sb.push_back(e);
  endtask

  // Monitor: compares the queued expectation on pixel 0 of each new frame.
  initial begin
    frame_t e;
    frame_t a;
    forever begin
      @(posedge clk);
      if (next_frame) begin
        #1;
        if (sb.size() > 0) begin
          e = sb.pop_front();
          a = {blank, pattern_sel, pattern_enable};
          check("frame{blank,sel,enable}", int'(a), int'(e));
        end
      end
    end
  end

  task automatic wait_frame();
    bit seen = 1'b0;
    for (int i = 0; i < 4 * FRAME && !seen; i++) begin
      @(posedge clk);
      if (next_frame) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      $display("FAIL wait_frame: got no next_frame expected one within %0d cycles", 4 * FRAME);
    end
    #2;
  endtask

  task automatic pulse_speed(input bit up, input bit dn);
    @(negedge clk);
    speed_up   = up;
    speed_down = dn;
    @(negedge clk);
    speed_up   = 1'b0;
    speed_down = 1'b0;
  endtask

  task automatic press(input int width);
    @(negedge clk);
    btn_next = 1'b1;
    repeat (width) @(negedge clk);
    btn_next = 1'b0;
  endtask

  initial begin
    #3 rst = 1'b1;
    wait_frame();
    check("reset sel", int'(pattern_sel), 0);
    check("reset enable", int'(pattern_enable), 1);
    check("reset blank", int'(blank), 0);
    check("reset step", int'(step_size), 2);

    // Auto sequencing through the wrap: 0,1,2,0.
    rst     = 1'b0;
    auto_en = 1'b1;
    push_frame(0, 0, 4);
    push_frame(1, 0, 2);
    push_frame(0, 1, 5);
    push_frame(1, 1, 2);
    push_frame(0, 2, 5);
    push_frame(1, 2, 2);
    push_frame(0, 0, 1);
    repeat (21) wait_frame();

    // Manual advance with auto disabled.
    auto_en = 1'b0;
    push_frame(1, 0, 2);
    push_frame(0, 1, 3);
    @(negedge clk);
    btn_next = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("pending after 3 cycles", int'(dut.pending), 1);
    repeat (2) @(negedge clk);
    btn_next = 1'b0;
    repeat (5) wait_frame();
    check("manual dwell held", int'(dut.dwell_cnt), 0);
    check("manual pending cleared", int'(dut.pending), 0);

    // Speed saturation and simultaneous up/down.
    @(negedge clk);
    speed_up = 1'b1;
    @(posedge clk);
    #1;
    check("step latency", int'(step_size), 3);
    @(negedge clk);
    speed_up = 1'b0;
    repeat (9) pulse_speed(1, 0);
    check("step sat high", int'(step_size), 7);
    repeat (10) pulse_speed(0, 1);
    check("step sat low", int'(step_size), 0);
    repeat (3) pulse_speed(1, 0);
    check("step at 3", int'(step_size), 3);
    pulse_speed(1, 1);
    check("step up+down", int'(step_size), 3);

    // Reset asserted in the middle of a blank frame.
    wait_frame();
    press(5);
    wait_frame();
    check("pre-reset blank", int'(blank), 1);
    check("pre-reset enable", int'(pattern_enable), 0);
    #50;
    rst = 1'b1;
    #1;
    check("mid-blank reset sel", int'(pattern_sel), 0);
    check("mid-blank reset enable", int'(pattern_enable), 1);
    check("mid-blank reset blank", int'(blank), 0);
    check("mid-blank reset step", int'(step_size), 2);
    check("mid-blank reset pending", int'(dut.pending), 0);
    @(negedge clk);
    rst = 1'b0;

    // Three presses in one RUN frame coalesce; a press during BLANK queues a second switch.
    wait_frame();
    push_frame(1, 0, 2);
    push_frame(0, 1, 1);
    push_frame(1, 1, 2);
    push_frame(0, 2, 2);
    repeat (3) begin
      press(2);
      repeat (2) @(negedge clk);
    end
    wait_frame();
    press(5);
    repeat (6) wait_frame();
    check("queued pending cleared", int'(dut.pending), 0);

    // Button edge lands on the auto-switch next_frame: one switch, pending stays 0.
    auto_en = 1'b1;
    push_frame(0, 2, 4);
    push_frame(1, 2, 2);
    push_frame(0, 0, 2);
    repeat (4) wait_frame();
    repeat (17) @(posedge clk);
    @(negedge clk);
    btn_next = 1'b1;
    wait_frame();
    repeat (2) @(negedge clk);
    btn_next = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("collision pending", int'(dut.pending), 0);
    repeat (3) wait_frame();

    check("scoreboard drained", sb.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("%0d/%0d checks passed", passes, checks + 1);
    $fatal(1, "watchdog");
  end

endmodule
